// File: rtl/ps2_kbd_cmd_arb_if.sv
// Purpose : groups requester A/B command handshakes and the ps2_kbd_host enqueue/status lines.
// Latency : none, this is a bundle of wires.
// Backpressure: a requester holds *_req_i until it sees *_grant_o. One command is in flight at a time.
// Ports (slave = arbiter side):
//   a_/b_ req_i, two_i, cmd_i[7:0], data_i[7:0] in; grant_o, done_o, result_o[7:0] out
//   kbd_wcmddata_o[7:0], kbd_enq_cmd1_o, kbd_enq_cmd2_o out; kbd_stat_i[7:0] in
//   busy_o, owner_o out
interface ps2_kbd_cmd_arb_if;
  logic       a_req_i;
  logic       a_two_i;
  logic [7:0] a_cmd_i;
  logic [7:0] a_data_i;
  logic       a_grant_o;
  logic       a_done_o;
  logic [7:0] a_result_o;

  logic       b_req_i;
  logic       b_two_i;
  logic [7:0] b_cmd_i;
  logic [7:0] b_data_i;
  logic       b_grant_o;
  logic       b_done_o;
  logic [7:0] b_result_o;

  logic [7:0] kbd_wcmddata_o;
  logic       kbd_enq_cmd1_o;
  logic       kbd_enq_cmd2_o;
  logic [7:0] kbd_stat_i;

  logic       busy_o;
  logic       owner_o;

  modport slave (
    input  a_req_i, a_two_i, a_cmd_i, a_data_i,
    input  b_req_i, b_two_i, b_cmd_i, b_data_i,
    input  kbd_stat_i,
    output a_grant_o, a_done_o, a_result_o,
    output b_grant_o, b_done_o, b_result_o,
    output kbd_wcmddata_o, kbd_enq_cmd1_o, kbd_enq_cmd2_o,
    output busy_o, owner_o
  );

  modport master (
    output a_req_i, a_two_i, a_cmd_i, a_data_i,
    output b_req_i, b_two_i, b_cmd_i, b_data_i,
    output kbd_stat_i,
    input  a_grant_o, a_done_o, a_result_o,
    input  b_grant_o, b_done_o, b_result_o,
    input  kbd_wcmddata_o, kbd_enq_cmd1_o, kbd_enq_cmd2_o,
    input  busy_o, owner_o
  );
endinterface

// File: rtl/ps2_kbd_cmd_arb.sv
// Purpose : round-robin arbiter/sequencer of PS2 keyboard commands from requesters A and B;
//           enqueues to ps2_kbd_host, waits for the reply, retries on 0xFE, times out a dead keyboard.
// Latency : grant in the request cycle; first enqueue the next cycle; done 1 cycle after the reply/timeout.
// Backpressure: requests are held off (no grant) while a command is in flight.
// Ports   : clk6x (48MHz), resetn (async active-low), ck1us (1us tick), bus (slave side of ps2_kbd_cmd_arb_if).
module ps2_kbd_cmd_arb #(
  parameter int TIMEOUT_US = 20000,
  parameter int MAX_RETRY  = 2
) (
  input  logic                 clk6x,
  input  logic                 resetn,
  input  logic                 ck1us,
  ps2_kbd_cmd_arb_if.slave     bus
);

  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_US - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [7:0] STAT_PEND = 8'h01;
  localparam logic [7:0] STAT_ACK  = 8'hFA;
  localparam logic [7:0] STAT_ERR  = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENQ_CMD,
    S_ENQ_DATA,
    S_WAIT_PEND,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_two;
  logic [7:0]    r_cmd;
  logic [7:0]    r_data;
  logic          r_owner;
  logic          r_last_b;     // 1 when B was the last one served
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_a_result;
  logic [7:0]    r_b_result;
  logic [7:0]    r_wlast;      // keeps the TX byte stable outside enqueue cycles

  logic          w_pick_b;
  logic          w_a_grant;
  logic          w_b_grant;
  logic          w_enq1;
  logic          w_enq2;
  logic [7:0]    w_wdata;
  logic [7:0]    w_res;
  logic          w_retry_inc;
  logic          w_in_wait;
  logic          w_tmo;

  // On a tie the requester that was not served last wins.
  assign w_pick_b  = bus.b_req_i & (~bus.a_req_i | ~r_last_b);
  assign w_in_wait = (r_state == S_WAIT_PEND) || (r_state == S_WAIT_RESP);
  // This tick would be the TIMEOUT_US-th one spent in the current wait state.
  assign w_tmo     = ck1us & (r_timer == TO_LAST);

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_grant   = 1'b0;
    w_b_grant   = 1'b0;
    w_enq1      = 1'b0;
    w_enq2      = 1'b0;
    w_wdata     = r_wlast;
    w_res       = 8'h00;
    w_retry_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.a_req_i || bus.b_req_i) begin
          w_b_grant   = w_pick_b;
          w_a_grant   = ~w_pick_b;
          w_state_nxt = S_ENQ_CMD;
        end
      end
      S_ENQ_CMD: begin
        w_wdata = r_cmd;
        if (r_two) begin
          w_enq2      = 1'b1;
          w_state_nxt = S_ENQ_DATA;
        end else begin
          w_enq1      = 1'b1;
          w_state_nxt = S_WAIT_PEND;
        end
      end
      S_ENQ_DATA: begin
        w_wdata     = r_data;
        w_enq2      = 1'b1;
        w_state_nxt = S_WAIT_PEND;
      end
      S_WAIT_PEND: begin
        // A leftover 0xFA/0xFE from the previous command must not complete this one.
        if (bus.kbd_stat_i == STAT_PEND) begin
          w_state_nxt = S_WAIT_RESP;
        end else if (w_tmo) begin
          w_res       = 8'h00;
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT_RESP: begin
        if (bus.kbd_stat_i == STAT_ACK) begin
          w_res       = STAT_ACK;
          w_state_nxt = S_DONE;
        end else if (bus.kbd_stat_i == STAT_ERR) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_inc = 1'b1;
            w_state_nxt = S_ENQ_CMD;
          end else begin
            w_res       = STAT_ERR;
            w_state_nxt = S_DONE;
          end
        end else if (w_tmo) begin
          w_res       = 8'h00;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      r_two      <= 1'b0;
      r_cmd      <= 8'h00;
      r_data     <= 8'h00;
      r_owner    <= 1'b0;
      r_last_b   <= 1'b1;
      r_retry    <= '0;
      r_timer    <= '0;
      r_a_result <= 8'h00;
      r_b_result <= 8'h00;
      r_wlast    <= 8'h00;
    end else begin
      r_wlast <= w_wdata;

      if (w_a_grant) begin
        r_two   <= bus.a_two_i;
        r_cmd   <= bus.a_cmd_i;
        r_data  <= bus.a_data_i;
        r_owner <= 1'b0;
        r_retry <= '0;
      end else if (w_b_grant) begin
        r_two   <= bus.b_two_i;
        r_cmd   <= bus.b_cmd_i;
        r_data  <= bus.b_data_i;
        r_owner <= 1'b1;
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + RW'(1);
      end

      // Any state change restarts the timer, so each wait state gets its own budget.
      if (w_state_nxt != r_state) begin
        r_timer <= '0;
      end else if (w_in_wait && ck1us) begin
        r_timer <= r_timer + TW'(1);
      end

      // Result is loaded on entry to DONE so it is valid alongside the done pulse.
      if (w_state_nxt == S_DONE) begin
        if (r_owner) begin
          r_b_result <= w_res;
        end else begin
          r_a_result <= w_res;
        end
      end

      if (r_state == S_DONE) begin
        r_last_b <= r_owner;
      end
    end
  end

  assign bus.a_grant_o      = w_a_grant;
  assign bus.b_grant_o      = w_b_grant;
  assign bus.a_done_o       = (r_state == S_DONE) & ~r_owner;
  assign bus.b_done_o       = (r_state == S_DONE) &  r_owner;
  assign bus.a_result_o     = r_a_result;
  assign bus.b_result_o     = r_b_result;
  assign bus.kbd_wcmddata_o = w_wdata;
  assign bus.kbd_enq_cmd1_o = w_enq1;
  assign bus.kbd_enq_cmd2_o = w_enq2;
  assign bus.busy_o         = (r_state != S_IDLE);
  assign bus.owner_o        = r_owner;

endmodule
